// File: rtl/sram_port_pkg.sv
// Shared types and constants for the 32-bit word port in front of the 512x8 SRAM macro.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    // Macro bit write enables are active low.
    localparam logic [7:0] WEN_ALL_ON  = 8'h00;
    localparam logic [7:0] WEN_ALL_OFF = 8'hFF;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sram_word_port.sv
// Word (32-bit) valid/ready port that serialises each access into four little-endian byte accesses on a 512x8 SRAM macro.
// Latency: write response in cycle 5 after accept, read response in cycle 6 (one extra cycle to catch the last macro Q).
// Backpressure: one request outstanding; req_ready only in IDLE; rsp_valid/rsp_rdata held until rsp_ready.
//
// Ports:
//   clk, rst                        clock (also the macro clock), async active-high reset
//   req_valid/req_ready             request handshake; req_we, req_addr (word), req_wdata, req_wstrb
//   rsp_valid/rsp_ready, rsp_rdata  response handshake; read data (0 for writes)
//   ram_cen/gwen/wen/a/d, ram_q     macro pins (active-low enables), all driven from flops
module sram_word_port
    import sram_port_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-3:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [7:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [1:0]        byte_q, byte_d;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic              accept;
    logic              issue_en;
    logic [1:0]        issue_byte;
    logic              cap_en;
    logic [1:0]        cap_idx;

    // The first byte is issued off the accept edge, so the request fields come
    // straight from req_* in IDLE and from the latched copy afterwards.
    logic              cur_we;
    logic [ADDR_W-3:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_wstrb;

    logic              cen_d, gwen_d;
    logic [7:0]        wen_d, d_d;
    logic [ADDR_W-1:0] a_d;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = (state_q == IDLE) && req_valid;

    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byte_q    <= 2'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            ram_cen   <= 1'b1;
            ram_gwen  <= 1'b1;
            ram_wen   <= WEN_ALL_OFF;
            ram_a     <= '0;
            ram_d     <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            if (accept) begin
                we_q      <= req_we;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                rsp_rdata <= '0;
            end
            // ram_q is only looked at here, so X outside capture cycles never lands.
            if (cap_en) begin
                rsp_rdata[cap_idx*8 +: 8] <= ram_q;
            end
            ram_cen  <= cen_d;
            ram_gwen <= gwen_d;
            ram_wen  <= wen_d;
            ram_a    <= a_d;
            ram_d    <= d_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        issue_en   = 1'b0;
        issue_byte = 2'd0;
        cap_en     = 1'b0;
        cap_idx    = 2'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ISSUE;
                    byte_d   = 2'd0;
                    issue_en = 1'b1;
                end
            end
            ISSUE: begin
                // Q for the byte issued last cycle is on the pins now.
                if (!we_q && (byte_q != 2'd0)) begin
                    cap_en  = 1'b1;
                    cap_idx = byte_q - 2'd1;
                end
                if (byte_q == LAST_BYTE) begin
                    state_d = we_q ? RESP : DRAIN;
                end else begin
                    byte_d     = byte_q + 2'd1;
                    issue_en   = 1'b1;
                    issue_byte = byte_q + 2'd1;
                end
            end
            DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = LAST_BYTE;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next macro pin values; address and data hold when nothing is issued.
    always_comb begin
        cen_d  = 1'b1;
        gwen_d = 1'b1;
        wen_d  = WEN_ALL_OFF;
        a_d    = ram_a;
        d_d    = ram_d;
        if (issue_en) begin
            a_d = {cur_addr, issue_byte};
            if (!cur_we) begin
                cen_d = 1'b0;
            end else if (cur_wstrb[issue_byte]) begin
                cen_d  = 1'b0;
                gwen_d = 1'b0;
                wen_d  = WEN_ALL_ON;
                d_d    = cur_wdata[issue_byte*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_word_port.sv
// Directed bench for sram_word_port against a behavioural 512x8 macro model.
// Latency: checks write response in cycle 5, read response in cycle 6 after accept.
// Backpressure: exercises held responses and reset during an access.
module tb_sram_word_port;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-3:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              ram_cen;
    logic              ram_gwen;
    logic [7:0]        ram_wen;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_d;
    logic [7:0]        ram_q;

    always #5 clk = ~clk;

    sram_word_port #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wen   (ram_wen),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    // Macro model: synchronous, Q valid the cycle after a read, X otherwise.
    logic [7:0] mem [0:511];
    logic       mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
            ram_q <= 8'hxx;
        end else begin
            if (!ram_cen && ram_gwen) ram_q <= mem[ram_a];
            else                      ram_q <= 8'hxx;
            if (!ram_cen && !ram_gwen)
                mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
        end
    end

    int tests = 0;
    int fails = 0;

    logic              obs_cen  [1:8];
    logic              obs_gwen [1:8];
    logic [7:0]        obs_wen  [1:8];
    logic [ADDR_W-1:0] obs_a    [1:8];
    logic [7:0]        obs_d    [1:8];
    int                rsp_cycle;
    logic [31:0]       rsp_data;
    int                vld_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one word access and records macro pins for cycles 1..8 and the response.
    task automatic access(input logic we, input logic [ADDR_W-3:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("req_ready_before_access", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        tick();
        // Request pins are don't-care once accepted.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 7'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        rsp_cycle = -1;
        rsp_data  = '0;
        for (int n = 1; n <= 12; n++) begin
            if (n <= 8) begin
                obs_cen[n]  = ram_cen;
                obs_gwen[n] = ram_gwen;
                obs_wen[n]  = ram_wen;
                obs_a[n]    = ram_a;
                obs_d[n]    = ram_d;
            end
            if (rsp_valid) begin
                rsp_cycle = n;
                rsp_data  = rsp_rdata;
                break;
            end
            tick();
        end
        if (rsp_cycle > 0 && rsp_ready) tick();
    endtask

    initial begin
        tick();
        tick();
        mem_init = 1'b0;
        rst      = 1'b0;

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_ram_pins", 64'({ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
              64'({1'b1, 1'b1, 8'hFF, 9'd0, 8'h00}));

        // Full write to word 5
        access(1'b1, 7'd5, 32'h11223344, 4'hF);
        check("wr_addr_seq", 64'({obs_a[1], obs_a[2], obs_a[3], obs_a[4]}),
              64'({9'd20, 9'd21, 9'd22, 9'd23}));
        check("wr_data_seq", 64'({obs_d[1], obs_d[2], obs_d[3], obs_d[4]}), 64'(32'h44332211));
        check("wr_cen_seq", 64'({obs_cen[1], obs_cen[2], obs_cen[3], obs_cen[4], obs_cen[5]}), 64'(5'b00001));
        check("wr_gwen_seq", 64'({obs_gwen[1], obs_gwen[2], obs_gwen[3], obs_gwen[4]}), 64'(4'b0000));
        check("wr_wen_seq", 64'({obs_wen[1], obs_wen[2], obs_wen[3], obs_wen[4]}), 64'(32'h0));
        check("wr_rsp_cycle", 64'(rsp_cycle), 64'(5));
        check("wr_rsp_rdata", 64'(rsp_data), 64'(0));
        check("wr_mem", 64'({mem[23], mem[22], mem[21], mem[20]}), 64'(32'h11223344));
        check("wr_req_ready_after", 64'(req_ready), 64'(1));

        // Read word 5 back
        access(1'b0, 7'd5, 32'h0, 4'h0);
        check("rd_cen_seq", 64'({obs_cen[1], obs_cen[2], obs_cen[3], obs_cen[4], obs_cen[5]}), 64'(5'b00001));
        check("rd_gwen_seq", 64'({obs_gwen[1], obs_gwen[2], obs_gwen[3], obs_gwen[4]}), 64'(4'b1111));
        check("rd_rsp_cycle", 64'(rsp_cycle), 64'(6));
        check("rd_rsp_rdata", 64'(rsp_data), 64'(32'h11223344));

        // Partial write: bytes 0 and 2 only
        access(1'b1, 7'd5, 32'hAABBCCDD, 4'b0101);
        check("pw_cen_seq", 64'({obs_cen[1], obs_cen[2], obs_cen[3], obs_cen[4]}), 64'(4'b0101));
        check("pw_data_b0_b2", 64'({obs_d[1], obs_d[3]}), 64'(16'hDDBB));
        access(1'b0, 7'd5, 32'h0, 4'h0);
        check("pw_readback", 64'(rsp_data), 64'(32'h11BB33DD));

        // Write with no strobes: no macro access, response still returned
        access(1'b1, 7'd6, 32'h01020304, 4'h0);
        check("nostrb_cen_seq", 64'({obs_cen[1], obs_cen[2], obs_cen[3], obs_cen[4]}), 64'(4'b1111));
        check("nostrb_rsp_cycle", 64'(rsp_cycle), 64'(5));
        check("nostrb_mem", 64'({mem[27], mem[26], mem[25], mem[24]}), 64'(32'hBEBFBCBD));

        // Top word, then check byte 0 of the macro is untouched
        access(1'b1, 7'd127, 32'hDEADBEEF, 4'hF);
        check("top_wr_addr_seq", 64'({obs_a[1], obs_a[2], obs_a[3], obs_a[4]}),
              64'({9'd508, 9'd509, 9'd510, 9'd511}));
        access(1'b0, 7'd127, 32'h0, 4'h0);
        check("top_rd_rdata", 64'(rsp_data), 64'(32'hDEADBEEF));
        check("top_mem0", 64'(mem[0]), 64'(8'hA5));

        // Response backpressure for three cycles
        rsp_ready = 1'b0;
        access(1'b0, 7'd5, 32'h0, 4'h0);
        check("bp_rsp_cycle", 64'(rsp_cycle), 64'(6));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold", 64'({rsp_valid, rsp_rdata, req_ready, ram_cen}),
                  64'({1'b1, 32'h11BB33DD, 1'b0, 1'b1}));
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", 64'({req_ready, rsp_valid}), 64'({1'b1, 1'b0}));

        // Reset in cycle 3 of a read
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'd5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rst_mid_cen_active", 64'(ram_cen), 64'(0));
        rst = 1'b1;
        #1;
        check("rst_mid_pins", 64'({ram_cen, ram_gwen, ram_wen, ram_a, rsp_valid, req_ready}),
              64'({1'b1, 1'b1, 8'hFF, 9'd0, 1'b0, 1'b1}));
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_req_ready", 64'(req_ready), 64'(1));
        vld_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid) vld_seen++;
            tick();
        end
        check("rst_mid_no_rsp", 64'(vld_seen), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
